// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one 1-bit slice with a registered carry, LSB first, valid/ready on both sides.
// Optional signed-overflow flag output is enabled by defining ALU_SEQ_OVF_EN.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] r_sr;
  logic [1:0]       op_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;

  logic             b_eff, r_bit, c_nxt, arith;
  logic [WIDTH-1:0] word_nxt;

  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // One ALU slice; B is inverted for subtraction, with the carry seeded to 1 at accept.
  always_comb begin
    arith = op_q[1];
    b_eff = b_sr[0] ^ (op_q == OP_SUB);
    c_nxt = (a_sr[0] & b_eff) | (a_sr[0] & carry) | (b_eff & carry);
    unique case (op_q)
      OP_AND:  r_bit = a_sr[0] & b_sr[0];
      OP_OR:   r_bit = a_sr[0] | b_sr[0];
      default: r_bit = a_sr[0] ^ b_eff ^ carry;
    endcase
    word_nxt = {r_bit, r_sr};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      op_q      <= OP_AND;
      carry     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          op_q  <= op;
          carry <= (op == OP_SUB);
          cnt   <= '0;
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= word_nxt[WIDTH-1:1];
          carry <= c_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result    <= word_nxt;
            carry_out <= arith & c_nxt;
            zero      <= (word_nxt == '0);
`ifdef ALU_SEQ_OVF_EN
            // On the MSB step, carry still holds the carry into the MSB.
            ovf       <= arith & (carry ^ c_nxt);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq (WIDTH=8); checks ovf too when ALU_SEQ_OVF_EN is defined.
module tb_alu_serial_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b, result;
  logic         carry_out, zero;
`ifdef ALU_SEQ_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero)
`ifdef ALU_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      2'b00: e.r = x & y;
      2'b01: e.r = x | y;
      2'b10: begin
        s   = {1'b0, x} + {1'b0, y};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      default: begin
        s   = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]);
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op while IDLE, take the accepting edge, and optionally score it.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit score);
    op = o; a = x; b = y; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    check("in_ready_busy", in_ready, 0);
    if (score) sb.push_back(model(o, x, y));
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check("latency", n, W);
  endtask

  task automatic collect();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("out_valid", out_valid, 1);
    check("result", result, e.r);
    check("carry_out", carry_out, e.c);
    check("zero", zero, e.z);
`ifdef ALU_SEQ_OVF_EN
    check("ovf", ovf, e.v);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y, 1'b1);
    wait_out();
    collect();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_zero", zero, 0);
    rst_n = 1'b1;
    step();

    run(2'b10, 8'h3C, 8'h25);
    run(2'b10, 8'hFF, 8'h01);
    run(2'b11, 8'h10, 8'h20);
    run(2'b11, 8'h20, 8'h20);
    run(2'b00, 8'hF0, 8'h3C);
    run(2'b01, 8'hF0, 8'h3C);

    // Backpressure in DONE while a second op is pushed at the input.
    issue(2'b10, 8'h01, 8'h01, 1'b1);
    wait_out();
    op = 2'b10; a = 8'h10; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_result", result, 8'h02);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    collect();
    check("bp_idle_ready", in_ready, 1);
    in_valid = 1'b0;
    issue(2'b10, 8'h10, 8'h22, 1'b1);
    wait_out();
    collect();

    // Reset on the 4th SHIFT edge aborts the op.
    issue(2'b10, 8'h77, 8'h11, 1'b0);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_carry", carry_out, 0);
    check("mid_rst_zero", zero, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("mid_rst_no_valid", out_valid, 0);
    end
    run(2'b10, 8'h05, 8'h03);

`ifdef ALU_SEQ_OVF_EN
    run(2'b10, 8'h7F, 8'h01);
    run(2'b11, 8'h80, 8'h01);
    run(2'b10, 8'h01, 8'h01);
`endif

    for (int i = 0; i < 20; i++) run(2'($urandom), 8'($urandom), 8'($urandom));

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
